display_console: RTL and testbench
==================================

# display_console

Display-side consumer of the eLC-3 memory-mapped display interface. It accepts one character per CPU write to DDR and reports display-ready status for DSR bit 15. Each character is rendered into a COLS×ROWS text video RAM, with cursor tracking, control-character handling and hardware scrolling through a circular top-row offset. It sits between the memory control unit (DDR write strobe) and the video scan-out logic (VRAM write port, Top_Row).

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows on screen
- COL_W, 7, cursor column width
- ROW_W, 5, cursor/top-row width
- ADDR_W, 12, VRAM address width; must hold ROWS*COLS-1
- Clk  in  1  system clock; one clock domain
- Reset  in  1  synchronous, active-high
- Char_Valid  in  1  one-cycle strobe, asserted when the CPU writes DDR
- Char_In  in  8  character code (DDR[7:0])
- Ready  out  1  1 = idle and able to accept a character; drives DSR[15]
- VRAM_WE  out  1  video RAM write enable
- VRAM_Addr  out  ADDR_W  video RAM address = phys_row*COLS + col
- VRAM_Data  out  8  video RAM write data
- Top_Row  out  ROW_W  physical row shown at the top of the screen; used by scan-out
- Cursor_Col  out  COL_W  logical cursor column
- Cursor_Row  out  ROW_W  logical cursor row (0 = top line on screen)

## Operation
- States: IDLE, EXEC, CLR_LINE, CLR_ALL. Outputs are Moore, decoded from the state and registers.
- IDLE: Ready=1, VRAM_WE=0. When Char_Valid=1, Char_In is latched and the FSM moves to EXEC.
- Char_Valid while Ready=0 is dropped with no side effects. Software polls DSR before each write.
- Physical row: phys_row = Top_Row + Cursor_Row, minus ROWS if the sum is ≥ ROWS.
- EXEC (one cycle, Ready=0) acts on the latched code:
  - 0x20–0x7E (printable): VRAM_WE=1 at (phys_row, Cursor_Col), data = code, then Cursor_Col+1. If the new column equals COLS, perform a newline.
  - 0x0A (LF): newline.
  - 0x0D (CR): Cursor_Col=0. No write.
  - 0x08 (BS): if Cursor_Col>0, decrement Cursor_Col and write 0x20 at the new position. If Cursor_Col=0, no-op.
  - 0x0C (FF): Cursor_Col=0, Cursor_Row=0, Top_Row=0, then go to CLR_ALL.
  - Any other code: ignored. EXEC returns to IDLE.
- Newline:
  - Cursor_Col=0.
  - If Cursor_Row<ROWS-1: Cursor_Row+1, then IDLE.
  - Otherwise (scroll): Cursor_Row stays ROWS-1 and Top_Row advances by 1, wrapping ROWS-1→0. Go to CLR_LINE for physical row = old Top_Row, which is the new bottom line.
- CLR_LINE: a k counter runs 0..COLS-1, writing 0x20 at line_base+k with VRAM_WE=1 every cycle. Exits to IDLE after k=COLS-1.
- CLR_ALL: the counter runs 0..ROWS*COLS-1, writing 0x20 at address k. Exits to IDLE after the last write.
- Reset:
  - Ready=1, VRAM_WE=0, VRAM_Addr=0, VRAM_Data=0, Cursor_Col=0, Cursor_Row=0, Top_Row=0, state IDLE.
  - VRAM contents are not cleared; software issues FF.
  - Reset during any state aborts it immediately.

## Timing
- Char_Valid is accepted at edge N: EXEC occupies cycle N+1 with Ready=0.
  - A printable or BS write is presented during N+1.
  - Cursor and Top_Row registers update at the end of N+1.
- No clear: Ready=1 in N+2. Throughput is one character per 2 cycles.
- Scroll: CLR_LINE writes during cycles N+2..N+1+COLS; Ready=1 in N+2+COLS.
- FF: CLR_ALL writes during cycles N+2..N+1+ROWS*COLS; Ready=1 in N+2+ROWS*COLS.
- Printable at the last column of the last row: the character write happens in N+1, then the scroll clear follows as above.
- Char_Valid coincident with the cycle Ready returns to 1 is accepted. Ready is sampled in the same cycle as the strobe.
- Reset asserted in cycle M: all outputs hold their reset values from M+1.

## Test plan
- Reset, Char_Valid with 0x41 at N → N+1: VRAM_WE=1, Addr=0, Data=0x41, Ready=0. N+2: Ready=1, Cursor_Col=1.
- 80 × 0x78 back-to-back (each sent on Ready) → last write at Addr=79, then Cursor_Row=1, Cursor_Col=0, no clear cycles.
- 29 LF → Cursor_Row=29. 30th LF → Top_Row=1, 80 writes of 0x20 at Addr 0..79, Ready low for 81 cycles. A following 0x42 is written at Addr=0.
- BS at col 0 → no write, Ready back after 1 cycle. Type "abcde" then BS → write 0x20 at Addr 4, Cursor_Col=4.
- FF → 2400 writes of 0x20 at Addr 0..2399, cursor (0,0), Top_Row=0. A Char_Valid during the clear is dropped and the cursor is unchanged.
- Reset in the middle of CLR_ALL (k≈1000) → next cycle VRAM_WE=0, Ready=1, all counters 0.

Source files
------------

// File: rtl/display_console.sv
// display_console: character sink for the memory-mapped display.
// Renders each accepted character into a COLS x ROWS text VRAM, tracks the
// cursor, handles LF/CR/BS/FF and scrolls by rotating the physical top row.
module display_console #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned COL_W  = 7,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Char_Valid,
    input  logic [7:0]        Char_In,
    output logic              Ready,
    output logic              VRAM_WE,
    output logic [ADDR_W-1:0] VRAM_Addr,
    output logic [7:0]        VRAM_Data,
    output logic [ROW_W-1:0]  Top_Row,
    output logic [COL_W-1:0]  Cursor_Col,
    output logic [ROW_W-1:0]  Cursor_Row
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLR_LINE,
        ST_CLR_ALL
    } state_t;

    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CELL_LAST  = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ROW_W:0]    ROWS_S     = (ROW_W + 1)'(ROWS);
    localparam logic [7:0]        SPACE      = 8'h20;

    state_t              state_q, state_d;
    logic [7:0]          char_q, char_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    top_q, top_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;

    logic [ROW_W:0]      row_sum;
    logic [ROW_W-1:0]    phys_row;
    logic [ADDR_W-1:0]   cell_base;
    logic [COL_W-1:0]    prev_col;
    logic                printable;
    logic                do_nl;

    // Physical row of the cursor and the VRAM base address of that row
    always_comb begin
        row_sum = {1'b0, top_q} + {1'b0, row_q};
        if (row_sum >= ROWS_S) begin
            row_sum = row_sum - ROWS_S;
        end
        phys_row  = row_sum[ROW_W-1:0];
        cell_base = ADDR_W'(phys_row) * COLS_A;
        prev_col  = col_q - 1'b1;
        printable = (char_q >= 8'h20) && (char_q <= 8'h7E);
    end

    // Next-state logic: command decode, cursor movement and clear counters
    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        col_d       = col_q;
        row_d       = row_q;
        top_d       = top_q;
        k_d         = k_q;
        line_base_d = line_base_q;
        do_nl       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Char_Valid) begin
                    char_d  = Char_In;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (printable) begin
                    if (col_q == LAST_COL) begin
                        do_nl = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else if (char_q == 8'h0A) begin
                    do_nl = 1'b1;
                end else if (char_q == 8'h0D) begin
                    col_d = '0;
                end else if (char_q == 8'h08) begin
                    if (col_q != '0) begin
                        col_d = prev_col;
                    end
                end else if (char_q == 8'h0C) begin
                    col_d   = '0;
                    row_d   = '0;
                    top_d   = '0;
                    k_d     = '0;
                    state_d = ST_CLR_ALL;
                end
                // Scrolling: the old top physical row becomes the new bottom line
                if (do_nl) begin
                    col_d = '0;
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        top_d       = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
                        line_base_d = ADDR_W'(top_q) * COLS_A;
                        k_d         = '0;
                        state_d     = ST_CLR_LINE;
                    end
                end
            end
            ST_CLR_LINE: begin
                if (k_q == LINE_LAST) begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_CLR_ALL: begin
                if (k_q == CELL_LAST) begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state and registers
    always_comb begin
        Ready     = 1'b0;
        VRAM_WE   = 1'b0;
        VRAM_Addr = '0;
        VRAM_Data = '0;
        unique case (state_q)
            ST_IDLE: Ready = 1'b1;
            ST_EXEC: begin
                if (printable) begin
                    VRAM_WE   = 1'b1;
                    VRAM_Addr = cell_base + ADDR_W'(col_q);
                    VRAM_Data = char_q;
                end else if ((char_q == 8'h08) && (col_q != '0)) begin
                    VRAM_WE   = 1'b1;
                    VRAM_Addr = cell_base + ADDR_W'(prev_col);
                    VRAM_Data = SPACE;
                end
            end
            ST_CLR_LINE: begin
                VRAM_WE   = 1'b1;
                VRAM_Addr = line_base_q + k_q;
                VRAM_Data = SPACE;
            end
            ST_CLR_ALL: begin
                VRAM_WE   = 1'b1;
                VRAM_Addr = k_q;
                VRAM_Data = SPACE;
            end
            default: Ready = 1'b0;
        endcase
    end

    assign Top_Row    = top_q;
    assign Cursor_Col = col_q;
    assign Cursor_Row = row_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            char_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            top_q       <= '0;
            k_q         <= '0;
            line_base_q <= '0;
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            k_q         <= k_d;
            line_base_q <= line_base_d;
        end
    end

endmodule

// File: tb/tb_display_console.sv
// tb_display_console: scoreboard bench for display_console.
// A cursor model predicts every VRAM write; a negedge monitor pops and checks.
module tb_display_console;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        ready;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [4:0]  top_row;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    display_console #(
        .COLS(80), .ROWS(30), .COL_W(7), .ROW_W(5), .ADDR_W(12)
    ) dut (
        .Clk(clk), .Reset(reset), .Char_Valid(char_valid), .Char_In(char_in),
        .Ready(ready), .VRAM_WE(vram_we), .VRAM_Addr(vram_addr),
        .VRAM_Data(vram_data), .Top_Row(top_row), .Cursor_Col(cursor_col),
        .Cursor_Row(cursor_row)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  m_col = 0, m_row = 0, m_top = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every observed write must match the oldest prediction
    always @(negedge clk) begin : monitor
        wr_t w;
        if (!reset && vram_we) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'(vram_we), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check_eq("wr_addr", 32'(vram_addr), 32'(w.addr));
                check_eq("wr_data", 32'(vram_data), 32'(w.data));
            end
        end
    end

    task automatic push_wr(input int addr, input int data);
        wr_t w;
        w.addr = 12'(addr);
        w.data = 8'(data);
        exp_q.push_back(w);
    endtask

    task automatic model_newline();
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int k = 0; k < COLS; k++) push_wr(m_top * COLS + k, 8'h20);
            m_top = (m_top + 1) % ROWS;
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        int phys;
        phys = (m_top + m_row) % ROWS;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(phys * COLS + m_col, c);
            m_col++;
            if (m_col == COLS) model_newline();
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(phys * COLS + m_col, 8'h20);
            end
        end else if (c == 8'h0C) begin
            m_col = 0; m_row = 0; m_top = 0;
            for (int k = 0; k < ROWS * COLS; k++) push_wr(k, 8'h20);
        end
    endtask

    // Counts negedges until Ready is seen high; bounded
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready) check_eq("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Returns at the negedge of the EXEC cycle with the strobe dropped
    task automatic send_char(input logic [7:0] c);
        int cnt;
        wait_ready(cnt);
        char_valid = 1'b1;
        char_in    = c;
        model_char(c);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        check_eq({tag, "_col"}, 32'(cursor_col), 32'(m_col));
        check_eq({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        check_eq({tag, "_top"}, 32'(top_row), 32'(m_top));
    endtask

    initial begin
        int cnt;
        string s;

        do_reset();
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_we", 32'(vram_we), 32'd0);
        check_eq("rst_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_data", 32'(vram_data), 32'd0);
        check_cursor("rst");

        // First character: write presented in the EXEC cycle
        send_char(8'h41);
        check_eq("a_we", 32'(vram_we), 32'd1);
        check_eq("a_addr", 32'(vram_addr), 32'd0);
        check_eq("a_data", 32'(vram_data), 32'h41);
        check_eq("a_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        check_eq("a_ready_back", 32'(ready), 32'd1);
        check_eq("a_col", 32'(cursor_col), 32'd1);

        // Full line wraps to the next row without any clear
        do_reset();
        for (int i = 0; i < COLS; i++) send_char(8'h78);
        wait_ready(cnt);
        check_eq("wrap_ready_cycles", 32'(cnt), 32'd1);
        check_eq("wrap_row", 32'(cursor_row), 32'd1);
        check_eq("wrap_col", 32'(cursor_col), 32'd0);
        check_eq("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Scroll on the 30th line feed
        do_reset();
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A);
        wait_ready(cnt);
        check_eq("lf29_row", 32'(cursor_row), 32'd29);
        send_char(8'h0A);
        wait_ready(cnt);
        check_eq("scroll_ready_low", 32'(cnt), 32'd81);
        check_cursor("scroll");
        check_eq("scroll_top_abs", 32'(top_row), 32'd1);
        send_char(8'h42);
        wait_ready(cnt);
        check_eq("scroll_sb_empty", 32'(exp_q.size()), 32'd0);

        // Printable at bottom-right: character write then scroll clear
        for (int i = 0; i < COLS; i++) send_char(8'h30 + 8'(i % 10));
        wait_ready(cnt);
        check_cursor("br");
        check_eq("br_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backspace
        do_reset();
        send_char(8'h08);
        wait_ready(cnt);
        check_eq("bs0_ready_cycles", 32'(cnt), 32'd1);
        s = "abcde";
        for (int i = 0; i < 5; i++) send_char(s[i]);
        send_char(8'h08);
        wait_ready(cnt);
        check_eq("bs_col", 32'(cursor_col), 32'd4);
        send_char(8'h0D);
        send_char(8'h07);
        wait_ready(cnt);
        check_cursor("cr_bel");
        send_char(8'h5A);

        // Form feed with a strobe dropped mid-clear
        send_char(8'h0C);
        repeat (100) @(negedge clk);
        char_valid = 1'b1;
        char_in    = 8'h41;
        @(negedge clk);
        char_valid = 1'b0;
        wait_ready(cnt);
        check_eq("ff_ready_low", 32'(cnt + 101), 32'd2401);
        check_cursor("ff");
        check_eq("ff_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset aborting a full clear
        send_char(8'h0C);
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
        @(negedge clk);
        check_eq("abort_we", 32'(vram_we), 32'd0);
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_addr", 32'(vram_addr), 32'd0);
        check_cursor("abort");
        @(negedge clk);
        reset = 1'b0;
        send_char(8'h43);
        wait_ready(cnt);
        check_eq("abort_after_col", 32'(cursor_col), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
